// File: rtl/mdu_ctrl_pkg.sv
// Shared encodings for the multiply/divide sequencer: operation codes,
// FSM state encodings and small decode helpers.
package mdu_ctrl_pkg;

  localparam int MDU_WIDTH = 32;

  typedef enum logic [1:0] {
    MDU_OP_MULT  = 2'b00,
    MDU_OP_MULTU = 2'b01,
    MDU_OP_DIV   = 2'b10,
    MDU_OP_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [2:0] {
    MDU_ST_IDLE  = 3'd0,
    MDU_ST_PREP  = 3'd1,
    MDU_ST_CALC  = 3'd2,
    MDU_ST_FIXUP = 3'd3,
    MDU_ST_DONE  = 3'd4
  } mdu_st_e;

  // Divide ops have the MSB of the opcode set.
  function automatic logic op_is_div(mdu_op_e op);
    return op[1];
  endfunction

  // Signed ops (MULT, DIV) have the LSB of the opcode clear.
  function automatic logic op_is_signed(mdu_op_e op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/mdu_iter_core.sv
// Radix-2 iteration datapath shared by multiply and divide.
// Registers: hi (partial product / partial remainder), lo (multiplier /
// dividend being shifted into quotient) and the fixed operand (multiplicand /
// divisor). Operands arrive as unsigned magnitudes; the carry / borrow bit
// that makes the working width WIDTH+1 lives in the combinational sum/trial
// terms, so the stored state stays WIDTH bits wide.
module mdu_iter_core
  import mdu_ctrl_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             step_i,
  input  logic             div_mode_i,
  input  logic [WIDTH-1:0] opnd_a_i,
  input  logic [WIDTH-1:0] opnd_b_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;

  // Multiply step: conditional add into the upper half, carry kept in bit WIDTH.
  logic [WIDTH:0]   mul_sum;
  // Divide step: shifted partial remainder and trial subtraction.
  logic [WIDTH:0]   div_shift;
  logic [WIDTH-1:0] div_diff;
  logic             div_ge;

  assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
  assign div_shift = {hi_q, lo_q[WIDTH-1]};
  assign div_ge    = (div_shift >= {1'b0, opnd_q});
  // When the trial succeeds the true difference is below the divisor, so the
  // low WIDTH bits of the wrapped subtraction are exact.
  assign div_diff  = div_shift[WIDTH-1:0] - opnd_q;

  // Next-state for the working registers: load, one iteration, or hold.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    hi_d   = hi_q;
    lo_d   = lo_q;
    opnd_d = opnd_q;
    if (load_i) begin
      hi_d   = '0;
      lo_d   = opnd_a_i;
      opnd_d = opnd_b_i;
    end else if (step_i) begin
      if (div_mode_i) begin
        hi_d = div_ge ? div_diff : div_shift[WIDTH-1:0];
        lo_d = {lo_q[WIDTH-2:0], div_ge};
      end else begin
        {hi_d, lo_d} = {mul_sum, lo_q[WIDTH-1:1]};
      end
    end
  end

  // Working registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so all registers update from pre-edge values.
    if (!rst) begin
      hi_q   <= '0;
      lo_q   <= '0;
      opnd_q <= '0;
    end else begin
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      opnd_q <= opnd_d;
    end
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;

endmodule

// File: rtl/mdu_ctrl.sv
// Multi-cycle multiply/divide sequencer for the EX stage. Owns the HI/LO
// write port, stalls IF/ID/EX while iterating, and handles sign fix-up,
// divide-by-zero and flush/cancel. ITERS must equal WIDTH.
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH,
  parameter int ITERS = MDU_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             cancel,
  output logic             stall_req,
  output logic             busy,
  output logic             hi_we,
  output logic             lo_we,
  output logic [WIDTH-1:0] hi_wdata,
  output logic [WIDTH-1:0] lo_wdata
);

  localparam int CNT_W = $clog2(ITERS);

  mdu_st_e          state_q, state_d;
  mdu_op_e          op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             neg_quo_q, neg_quo_d;   // sign of quotient / product
  logic             neg_rem_q, neg_rem_d;   // sign of remainder (dividend sign)
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] res_hi_q, res_hi_d;
  logic [WIDTH-1:0] res_lo_q, res_lo_d;

  logic             accept;
  logic             is_signed;
  logic             div_zero;
  logic             cnt_last;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH-1:0] core_hi, core_lo;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic             wr_en;

  assign accept    = (state_q == MDU_ST_IDLE) && start && !cancel;
  assign is_signed = op_is_signed(op_q);
  assign div_zero  = op_is_div(op_q) && (b_q == '0);
  assign cnt_last  = (cnt_q == CNT_W'(ITERS - 1));
  assign mag_a     = (is_signed && a_q[WIDTH-1]) ? -a_q : a_q;
  assign mag_b     = (is_signed && b_q[WIDTH-1]) ? -b_q : b_q;
  assign prod      = {core_hi, core_lo};
  assign prod_fix  = neg_quo_q ? -prod : prod;

  mdu_iter_core #(.WIDTH(WIDTH)) u_core (
    .clk        (clk),
    .rst        (rst),
    .load_i     (state_q == MDU_ST_PREP),
    .step_i     (state_q == MDU_ST_CALC),
    .div_mode_i (op_is_div(op_q)),
    .opnd_a_i   (mag_a),
    .opnd_b_i   (mag_b),
    .hi_o       (core_hi),
    .lo_o       (core_lo)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state_q <= MDU_ST_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic; cancel returns to IDLE from anywhere.
  always_comb begin
    state_d = state_q;
    if (cancel) begin
      state_d = MDU_ST_IDLE;
    end else begin
      unique case (state_q)
        MDU_ST_IDLE:  if (start) state_d = MDU_ST_PREP;
        MDU_ST_PREP:  state_d = div_zero ? MDU_ST_DONE : MDU_ST_CALC;
        MDU_ST_CALC:  if (cnt_last) state_d = MDU_ST_FIXUP;
        MDU_ST_FIXUP: state_d = MDU_ST_DONE;
        MDU_ST_DONE:  state_d = MDU_ST_IDLE;
        default:      state_d = MDU_ST_IDLE;
      endcase
    end
  end

  // Outputs: stall while the op is live, one write pulse in DONE unless flushed.
  always_comb begin
    busy      = (state_q != MDU_ST_IDLE);
    stall_req = !cancel && (((state_q == MDU_ST_IDLE) && start) ||
                            (state_q == MDU_ST_PREP) ||
                            (state_q == MDU_ST_CALC) ||
                            (state_q == MDU_ST_FIXUP));
    wr_en     = (state_q == MDU_ST_DONE) && !cancel;
    hi_we     = wr_en;
    lo_we     = wr_en;
    hi_wdata  = wr_en ? res_hi_q : '0;
    lo_wdata  = wr_en ? res_lo_q : '0;
  end

  // Operand capture, sign recording, iteration count and result fix-up.
  always_comb begin
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    cnt_d     = (state_q == MDU_ST_CALC) ? cnt_q + CNT_W'(1) : '0;
    res_hi_d  = res_hi_q;
    res_lo_d  = res_lo_q;

    if (accept) begin
      op_d = mdu_op_e'(op);
      a_d  = src_a;
      b_d  = src_b;
    end

    if (state_q == MDU_ST_PREP) begin
      neg_quo_d = is_signed && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
      neg_rem_d = is_signed && a_q[WIDTH-1];
      if (div_zero) begin
        res_hi_d = a_q;
        res_lo_d = '1;
      end
    end

    if (state_q == MDU_ST_FIXUP) begin
      if (op_is_div(op_q)) begin
        res_hi_d = neg_rem_q ? -core_hi : core_hi;
        res_lo_d = neg_quo_q ? -core_lo : core_lo;
      end else begin
        {res_hi_d, res_lo_d} = prod_fix;
      end
    end
  end

  // Control-side registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      op_q      <= MDU_OP_MULT;
      a_q       <= '0;
      b_q       <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      cnt_q     <= '0;
      res_hi_q  <= '0;
      res_lo_q  <= '0;
    end else begin
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      cnt_q     <= cnt_d;
      res_hi_q  <= res_hi_d;
      res_lo_q  <= res_lo_d;
    end
  end

endmodule
